// File: rtl/opseq_pkg.sv
// Shared types and constants for the opcode sequencer: FSM states, error-flag
// bit positions and the NOP opcode value.
package opseq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } opseq_state_t;

    localparam int ERR_OVF = 0;
    localparam int ERR_FRM = 1;
    localparam int ERR_TMO = 2;

    localparam logic [13:0] NOP_OPCODE = 14'h0000;

endpackage

// File: rtl/opseq_fifo.sv
// Synchronous opcode FIFO with first-word-fall-through head; a push while full
// is accepted when a pop happens in the same cycle.
module opseq_fifo #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rptr];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
            else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= i_data;
    end

endmodule

// File: rtl/opcode_sequencer.sv
// Assembles two-beat opcodes, queues them, issues each to the core array and
// gathers the serial result. Optional WAIT timeout: define OPSEQ_TIMEOUT_EN.
module opcode_sequencer
    import opseq_pkg::*;
#(
    parameter int OPCODE_W    = 14,
    parameter int BEAT_W      = 7,
    parameter int FIFO_DEPTH  = 4,
    parameter int RESULT_BITS = 8,
    parameter int TIMEOUT     = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [BEAT_W-1:0]      beat_in,
    input  logic                   beat_valid,
    input  logic                   beat_first,
    output logic [OPCODE_W-1:0]    opcode_out,
    output logic                   execute,
    input  logic                   core_valid,
    input  logic                   core_bit,
    output logic [RESULT_BITS-1:0] result_bits,
    output logic                   result_ready,
    output logic                   fifo_full,
    output logic                   fifo_empty,
    output logic                   busy,
    output logic [2:0]             err_flags
);
    localparam int BCW = $clog2(RESULT_BITS + 1);
    localparam logic [BCW-1:0]      LAST_BIT = BCW'(RESULT_BITS - 1);
    localparam logic [OPCODE_W-1:0] NOP      = OPCODE_W'(NOP_OPCODE);

    opseq_state_t           r_state;
    logic [BEAT_W-1:0]      r_hi;
    logic                   r_half_pending;
    logic                   r_err_ovf;
    logic                   r_err_frm;
    logic [OPCODE_W-1:0]    r_opcode;
    logic                   r_execute;
    logic [BCW-1:0]         r_bit_cnt;
    logic [RESULT_BITS-1:0] r_shift;
    logic [RESULT_BITS-1:0] r_result;
    logic                   r_ready;
    logic                   w_push_req;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_empty;
    logic [OPCODE_W-1:0]    w_head;

    assign w_push_req = beat_valid & ~beat_first & r_half_pending;
    assign w_pop      = (r_state == ST_IDLE) & ~w_empty;

    opseq_fifo #(.WIDTH(OPCODE_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push_req),
        .i_data  ({r_hi, beat_in}),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // A repeated first beat silently restarts the opcode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi           <= '0;
            r_half_pending <= 1'b0;
            r_err_ovf      <= 1'b0;
            r_err_frm      <= 1'b0;
        end else if (beat_valid) begin
            if (beat_first) begin
                r_hi           <= beat_in;
                r_half_pending <= 1'b1;
            end else if (r_half_pending) begin
                r_half_pending <= 1'b0;
                if (w_full && !w_pop) r_err_ovf <= 1'b1;
            end else begin
                r_err_frm <= 1'b1;
            end
        end
    end

`ifdef OPSEQ_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT + 1);
    localparam logic [TCW-1:0] TMO_LAST = TCW'(TIMEOUT - 1);
    logic [TCW-1:0] r_tmo_cnt;
    logic           r_tmo_flag;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT > 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_opcode  <= '0;
            r_execute <= 1'b0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_result  <= '0;
            r_ready   <= 1'b0;
`ifdef OPSEQ_TIMEOUT_EN
            r_tmo_cnt  <= '0;
            r_tmo_flag <= 1'b0;
`endif
        end else begin
            r_execute <= 1'b0;
            r_ready   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty && w_head != NOP) begin
                        r_opcode  <= w_head;
                        r_execute <= 1'b1;
                        r_state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_bit_cnt <= '0;
`ifdef OPSEQ_TIMEOUT_EN
                    r_tmo_cnt <= '0;
`endif
                    r_state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (core_valid) begin
                        r_shift   <= {r_shift[RESULT_BITS-2:0], core_bit};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
`ifdef OPSEQ_TIMEOUT_EN
                        r_tmo_cnt <= '0;
`endif
                        if (r_bit_cnt == LAST_BIT) r_state <= ST_DONE;
                    end
`ifdef OPSEQ_TIMEOUT_EN
                    else if (r_tmo_cnt == TMO_LAST) begin
                        r_tmo_flag <= 1'b1;
                        r_state    <= ST_IDLE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
`endif
                end
                ST_DONE: begin
                    r_result <= r_shift;
                    r_ready  <= 1'b1;
                    r_state  <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign opcode_out   = r_opcode;
    assign execute      = r_execute;
    assign result_bits  = r_result;
    assign result_ready = r_ready;
    assign fifo_full    = w_full;
    assign fifo_empty   = w_empty;
    assign busy         = (r_state != ST_IDLE);
`ifdef OPSEQ_TIMEOUT_EN
    assign err_flags    = {r_tmo_flag, r_err_frm, r_err_ovf};
`else
    assign err_flags    = {1'b0, r_err_frm, r_err_ovf};
`endif

endmodule
